// File: rtl/parambuttondebouncer.sv
// Multi-channel push-button debouncer: sync chain, stability counter, press/release pulses per channel.
// Latency: SYNCSTAGES + THRESH rising edges from first sampling of a new stable level to OUTBTN/pulse.
// No backpressure: free-running, one new sample per channel every cycle.
//
// Ports:
//   IPTCLK      system clock, all state on rising edge
//   IPTRSTN     asynchronous active-low reset (release synchronous to IPTCLK at board level)
//   IPTBTN      raw asynchronous button levels, one bit per channel
//   OUTBTN      debounced level per channel, 1 = pressed
//   OUTPRESS    one-cycle pulse in the first cycle OUTBTN[i] reads 1
//   OUTRELEASE  one-cycle pulse in the first cycle OUTBTN[i] reads 0
//   OUTANY      OR of OUTBTN
module parambuttondebouncer #(
    parameter int CHANNELS   = 4,
    parameter int CNTBITS    = 4,
    parameter int THRESH     = 15,
    parameter int SYNCSTAGES = 2,
    parameter int ACTIVELOW  = 0
) (
    input  logic                IPTCLK,
    input  logic                IPTRSTN,
    input  logic [CHANNELS-1:0] IPTBTN,
    output logic [CHANNELS-1:0] OUTBTN,
    output logic [CHANNELS-1:0] OUTPRESS,
    output logic [CHANNELS-1:0] OUTRELEASE,
    output logic                OUTANY
);

    // Inverting ahead of the synchroniser makes a reset-zeroed chain mean "released"
    // regardless of button polarity.
    localparam logic [CHANNELS-1:0] INV_MASK = (ACTIVELOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
    localparam logic [CNTBITS-1:0]  LAST_CNT = CNTBITS'(THRESH - 1);

    logic [CHANNELS-1:0] sync_q [SYNCSTAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] st_q;
    logic [CNTBITS-1:0]  cnt_q [CHANNELS];
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] release_q;
    logic [CHANNELS-1:0] differ;
    logic [CHANNELS-1:0] accept;

    // Synchroniser chain, stage 0 samples the (polarity-corrected) raw input.
    always_ff @(posedge IPTCLK or negedge IPTRSTN) begin
        if (!IPTRSTN) begin
            for (int i = 0; i < SYNCSTAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= IPTBTN ^ INV_MASK;
            for (int i = 1; i < SYNCSTAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNCSTAGES-1];
    assign differ = sync_s ^ st_q;

    // A change is taken on the edge where the counter already shows THRESH-1 earlier
    // disagreeing edges, so THRESH disagreeing edges in a row are needed in total.
    always_comb begin
        accept = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            accept[ch] = differ[ch] && (cnt_q[ch] == LAST_CNT);
        end
    end

    always_ff @(posedge IPTCLK or negedge IPTRSTN) begin
        if (!IPTRSTN) begin
            st_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            st_q      <= st_q ^ accept;
            press_q   <= accept & sync_s;
            release_q <= accept & ~sync_s;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                // Any agreeing cycle restarts the count; counter stops at THRESH-1, no wrap.
                if (!differ[ch] || accept[ch]) begin
                    cnt_q[ch] <= '0;
                end else begin
                    cnt_q[ch] <= cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    assign OUTBTN     = st_q;
    assign OUTPRESS   = press_q;
    assign OUTRELEASE = release_q;
    assign OUTANY     = |st_q;

endmodule

// File: tb/tb_parambuttondebouncer.sv
// Bench for parambuttondebouncer: default instance (4 ch, THRESH 15, 2 sync stages)
// and an active-low instance (2 ch, THRESH 3, 3 sync stages), directed plus random stimulus.
// Reference model: per-channel history of sampled levels; a change is accepted when the last THRESH seen levels all differ.
module tb_parambuttondebouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ra;
    logic [1:0] rb;

    logic [3:0] btn_a, press_a, rel_a;
    logic       any_a;
    logic [1:0] btn_b, press_b, rel_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    // Model state: history of synchroniser inputs, newest at index 0.
    logic [3:0] ha [32];
    logic [3:0] hb [32];
    logic [3:0] st_a, ep_a, er_a;
    logic [3:0] st_b, ep_b, er_b;

    always #5 clk = ~clk;

    parambuttondebouncer dut_a (
        .IPTCLK(clk), .IPTRSTN(rst_n), .IPTBTN(ra),
        .OUTBTN(btn_a), .OUTPRESS(press_a), .OUTRELEASE(rel_a), .OUTANY(any_a)
    );

    parambuttondebouncer #(
        .CHANNELS(2), .CNTBITS(4), .THRESH(3), .SYNCSTAGES(3), .ACTIVELOW(1)
    ) dut_b (
        .IPTCLK(clk), .IPTRSTN(rst_n), .IPTBTN(rb),
        .OUTBTN(btn_b), .OUTPRESS(press_b), .OUTRELEASE(rel_b), .OUTANY(any_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channels whose last th synchronised samples (used at edges) all disagree with st.
    function automatic logic [3:0] changes(input logic [3:0] h [32], input logic [3:0] st,
                                           input int ss, input int th);
        logic [3:0] r;
        r = 4'b0;
        for (int ch = 0; ch < 4; ch++) begin
            r[ch] = 1'b1;
            for (int k = 0; k < th; k++) begin
                if (h[ss + k][ch] == st[ch]) r[ch] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 32; j++) begin
            ha[j] = 4'b0;
            hb[j] = 4'b0;
        end
        st_a = 4'b0; ep_a = 4'b0; er_a = 4'b0;
        st_b = 4'b0; ep_b = 4'b0; er_b = 4'b0;
    endtask

    task automatic model_edge();
        logic [3:0] ch;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int j = 31; j > 0; j--) begin
                ha[j] = ha[j-1];
                hb[j] = hb[j-1];
            end
            ha[0] = ra;
            hb[0] = {2'b00, ~rb};
            ch   = changes(ha, st_a, 2, 15);
            st_a = st_a ^ ch;
            ep_a = ch & st_a;
            er_a = ch & ~st_a;
            ch   = changes(hb, st_b, 3, 3);
            st_b = st_b ^ ch;
            ep_b = ch & st_b;
            er_b = ch & ~st_b;
        end
    endtask

    task automatic compare_all(input string pfx);
        check_eq({pfx, "_a_btn"}, 32'(btn_a), 32'(st_a));
        check_eq({pfx, "_a_press"}, 32'(press_a), 32'(ep_a));
        check_eq({pfx, "_a_rel"}, 32'(rel_a), 32'(er_a));
        check_eq({pfx, "_a_any"}, 32'(any_a), 32'(|st_a));
        check_eq({pfx, "_b_btn"}, 32'(btn_b), 32'(st_b[1:0]));
        check_eq({pfx, "_b_press"}, 32'(press_b), 32'(ep_b[1:0]));
        check_eq({pfx, "_b_rel"}, 32'(rel_b), 32'(er_b[1:0]));
        check_eq({pfx, "_b_any"}, 32'(any_b), 32'(|st_b[1:0]));
    endtask

    // Inputs are changed at the falling edge; one call = one rising edge, checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until the selected instance shows exactly the wanted pulses; report edges taken.
    task automatic measure(input string tag, input bit sel_b, input logic [3:0] wp,
                           input logic [3:0] wr, input int exp_n);
        int n;
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (sel_b ? ({2'b00, press_b} == wp && {2'b00, rel_b} == wr)
                      : (press_a == wp && rel_a == wr)) begin
                n = k;
                break;
            end
        end
        check_eq(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_btn"}, 32'({btn_a, btn_b}), 32'd0);
        check_eq({tag, "_pulse"}, 32'({press_a, rel_a, press_b, rel_b}), 32'd0);
        check_eq({tag, "_any"}, 32'({any_a, any_b}), 32'd0);
        @(negedge clk);
        settle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int rem_a [4];
        int rem_b [2];
        bit seen;

        ra = 4'b0000;
        rb = 2'b11;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // Clean press on channel 0.
        ra = 4'b0001;
        measure("clean_press_lat", 1'b0, 4'b0001, 4'b0000, 17);
        check_eq("clean_press_btn", 32'(btn_a), 32'h1);
        check_eq("clean_press_any", 32'(any_a), 32'h1);

        // Bounce on channel 1: 14 high / 1 low, five times.
        seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            ra[1] = 1'b1;
            for (int k = 0; k < 14; k++) begin
                step();
                if (press_a[1] || btn_a[1]) seen = 1'b1;
            end
            ra[1] = 1'b0;
            step();
            if (press_a[1] || btn_a[1]) seen = 1'b1;
        end
        check_eq("bounce_no_press", 32'(seen), 32'h0);
        ra[1] = 1'b1;
        measure("bounce_final_lat", 1'b0, 4'b0010, 4'b0000, 17);

        ra = 4'b0000;
        settle(20);
        check_eq("all_released", 32'(btn_a), 32'h0);

        // Simultaneous press and partial release.
        ra = 4'b1111;
        measure("simul_press_lat", 1'b0, 4'b1111, 4'b0000, 17);
        ra = 4'b0101;
        measure("simul_rel_lat", 1'b0, 4'b0000, 4'b1010, 17);

        // Release channel 2 from pressed state.
        ra = 4'b0001;
        measure("release2_lat", 1'b0, 4'b0000, 4'b0100, 17);
        check_eq("release2_btn", 32'(btn_a), 32'h1);

        // Reset mid-count on channel 3.
        ra = 4'b0000;
        settle(20);
        ra = 4'b1000;
        settle(12);
        apply_reset("mid_reset");
        measure("post_reset_lat", 1'b0, 4'b1000, 4'b0000, 17);

        // Active-low instance: raw idles high, press on channel 0, then a short glitch on channel 1.
        check_eq("b_idle_btn", 32'(btn_b), 32'h0);
        rb = 2'b10;
        measure("b_press_lat", 1'b1, 4'b0001, 4'b0000, 6);
        seen = 1'b0;
        rb = 2'b00;
        for (int k = 0; k < 2; k++) begin
            step();
            if (btn_b[1] || press_b[1]) seen = 1'b1;
        end
        rb = 2'b10;
        for (int k = 0; k < 10; k++) begin
            step();
            if (btn_b[1] || press_b[1]) seen = 1'b1;
        end
        check_eq("b_glitch_rejected", 32'(seen), 32'h0);

        // Random run-length stimulus around the thresholds.
        for (int i = 0; i < 4; i++) rem_a[i] = 0;
        for (int i = 0; i < 2; i++) rem_b[i] = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem_a[i] == 0) begin
                    ra[i] = ~ra[i];
                    rem_a[i] = $urandom_range(1, 20);
                end
                rem_a[i]--;
            end
            for (int i = 0; i < 2; i++) begin
                if (rem_b[i] == 0) begin
                    rb[i] = ~rb[i];
                    rem_b[i] = $urandom_range(1, 5);
                end
                rem_b[i]--;
            end
            if (cyc == 600) begin
                apply_reset("rand_reset");
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
